mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequencer and owner of the HI/LO register pair for the MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo requests from the EXE stage over a valid/ready handshake.
- Runs a fixed-latency multiply or a 32-iteration restoring divide, then commits the results to HI/LO.
- Provides HI/LO read data and a busy indication; the decode/execute interlock uses busy to stall mfhi/mflo and further MDU ops.

Parameters:
- MUL_LAT, 2, cycles from accept to the FINISH cycle for mult/multu; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  EXE presents an MDU request
- req_ready  out  1  MDU can accept a request this cycle
- mul_op  in  1  signed multiply
- mulu_op  in  1  unsigned multiply
- div_op  in  1  signed divide
- divu_op  in  1  unsigned divide
- hi_we  in  1  mthi
- lo_we  in  1  mtlo
- src1  in  32  rs value (dividend / multiplicand / mthi-mtlo data)
- src2  in  32  rt value (divisor / multiplier)
- cancel  in  1  flush from exception/refetch; aborts the in-flight op
- busy  out  1  an op is in flight; HI/LO not yet final
- done  out  1  pulse in the FINISH cycle of a committed mul/div
- hi_rdata  out  32  HI value for mfhi
- lo_rdata  out  32  LO value for mflo

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset result: state IDLE, HI=LO=0, busy=0, done=0, req_ready=1, counter=0.
- Handshake: an op fires on req_valid && req_ready. req_ready=1 only in IDLE, or in FINISH when MDU_HILO_FWD_EN is defined.
- Op decode: priority div_op > divu_op > mul_op > mulu_op > hi_we > lo_we. A fire with no op bit set is a no-op.
- mthi/mtlo:
  - Write at the end of the accept cycle; FSM stays in IDLE.
  - Visible on hi_rdata/lo_rdata from the next cycle; busy stays 0.
- FSM states: IDLE, MUL_WAIT, DIV_ITER, FINISH.
- Multiply:
  - Accept at cycle T latches the operands.
  - MUL_WAIT occupies T+1..T+MUL_LAT-1 (skipped when MUL_LAT=1).
  - FINISH at T+MUL_LAT.
  - The 64-bit product splits HI=[63:32], LO=[31:0]; signed or unsigned per op.
- Divide:
  - Accept at cycle T latches |src1|, |src2| (raw values for divu) and the operand signs.
  - DIV_ITER occupies T+1..T+32, one quotient bit per cycle; a 5-bit counter counts 31 down to 0.
  - FINISH at T+33 applies the sign fix: quotient truncates toward zero; remainder takes the sign of the dividend.
- FINISH:
  - done=1.
  - HI/LO written at the end of the cycle.
  - Next state IDLE, or directly the new op's state if a request fires (FWD only).
- busy=1 in MUL_WAIT and DIV_ITER. In FINISH, busy=1 without FWD and busy=0 with FWD.
- Divide by zero (both div and divu): HI=src1 (raw), LO=0xFFFFFFFF, with normal 33-cycle timing.
- Overflow case: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- cancel:
  - In any state, next state is IDLE, done is suppressed, and HI/LO are untouched, including when cancel is asserted in FINISH.
  - cancel together with req_valid in IDLE drops the request.
  - cancel does not undo an mthi/mtlo already written in an earlier cycle.
- reset mid-operation overrides everything and returns the block to its reset values.
- Operand inputs are sampled only at accept; they may change afterwards.

Optional Feature:
- Macro: MDU_HILO_FWD_EN.
- Defined:
  - In FINISH, hi_rdata/lo_rdata present the result being committed, and busy=0 / req_ready=1 in that same cycle.
  - An mthi/mtlo write in IDLE is likewise forwarded combinationally to the read port in the accept cycle.
- Not defined:
  - Read ports always show the registered HI/LO.
  - busy is held through FINISH, so a dependent mfhi stalls one extra cycle.

Decomposition:
- mycpu.h gets:
  - the MDU state encodings (2-bit);
  - the MDU op-field positions in the DS-to-ES bus;
  - the MDU_DIV_ITERS=32 constant.
- Sub-module div_iter: the restoring shift-subtract datapath.
  - Inputs: start, |dividend|, |divisor|.
  - Holds the 64-bit partial remainder and quotient registers.
  - Outputs the unsigned quotient and remainder.
  - mdu_ctrl owns the FSM, counter, sign fix, multiplier and HI/LO.

Test Plan:
- mult src1=0xFFFFFFFF, src2=2 -> done at T+2, HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- divu 100/7 -> busy T+1..T+33, done at T+33, LO=14, HI=2. div -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 5/0 -> LO=0xFFFFFFFF, HI=5 at T+33. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start divu, assert cancel at T+10 -> IDLE and req_ready=1 at T+11, no done, HI/LO keep their prior values. Repeat with cancel in the FINISH cycle -> HI/LO unchanged.
- mthi 0x1234 then back-to-back mult with req_valid held high -> second op accepted the cycle after mthi, HI reads 0x1234 until the mult commits.
- With MDU_HILO_FWD_EN: mult followed by an mflo poll -> lo_rdata correct and busy=0 in the FINISH cycle. Without the macro -> busy=1 in FINISH and the correct value appears one cycle later.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared encodings for the multiply/divide unit.
// State encodings, op-field bit positions within the MDU slice of the
// DS-to-ES bus, iteration count, and the op priority decoder.
package mdu_ctrl_pkg;

    // 2-bit sequencer states
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_ITER = 2'd2,
        S_FINISH   = 2'd3
    } mdu_state_e;

    // Decoded operation after priority resolution
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_MUL  = 3'd3,
        OP_MULU = 3'd4,
        OP_MTHI = 3'd5,
        OP_MTLO = 3'd6
    } mdu_op_e;

    // Bit positions of the MDU op field carried on the DS-to-ES bus
    localparam int MDU_OP_W   = 6;
    localparam int MDU_F_DIV  = 5;
    localparam int MDU_F_DIVU = 4;
    localparam int MDU_F_MUL  = 3;
    localparam int MDU_F_MULU = 2;
    localparam int MDU_F_MTHI = 1;
    localparam int MDU_F_MTLO = 0;

    localparam int MDU_DIV_ITERS = 32;

    // Priority: div > divu > mul > mulu > mthi > mtlo
    function automatic mdu_op_e mdu_decode(input logic [MDU_OP_W-1:0] f);
        mdu_op_e op;
        op = OP_NONE;
        if (f[MDU_F_DIV])       op = OP_DIV;
        else if (f[MDU_F_DIVU]) op = OP_DIVU;
        else if (f[MDU_F_MUL])  op = OP_MUL;
        else if (f[MDU_F_MULU]) op = OP_MULU;
        else if (f[MDU_F_MTHI]) op = OP_MTHI;
        else if (f[MDU_F_MTLO]) op = OP_MTLO;
        return op;
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// mdu_ctrl_div_iter: unsigned restoring shift-subtract divider datapath.
// The {remainder, quotient} pair lives in one 64-bit register; each step
// shifts it left and tries to subtract the divisor from the upper part.
module mdu_ctrl_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic [63:0] r_acc;
    logic [31:0] r_divisor;

    logic [32:0] w_part;
    logic        w_ge;
    logic [31:0] w_diff;

    // Shifted partial remainder is up to 33 bits; after a successful
    // subtract it is below the divisor, so 32 bits hold the difference.
    assign w_part = r_acc[63:31];
    assign w_ge   = (w_part >= {1'b0, r_divisor});
    assign w_diff = w_part[31:0] - r_divisor;

    // Load operands on start, otherwise retire one quotient bit per step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= 64'd0;
            r_divisor <= 32'd0;
        end else if (i_start) begin
            r_acc     <= {32'd0, i_dividend};
            r_divisor <= i_divisor;
        end else if (i_step) begin
            if (w_ge) r_acc <= {w_diff, r_acc[30:0], 1'b1};
            else      r_acc <= {r_acc[62:0], 1'b0};
        end
    end

    assign o_quot = r_acc[31:0];
    assign o_rem  = r_acc[63:32];

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS multiply/divide sequencer and HI/LO owner.
// Optional macro MDU_HILO_FWD_EN: forwards the committing result (and
// mthi/mtlo data) to the read ports and frees the unit in FINISH.
module mdu_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mul_op,
    input  logic        mulu_op,
    input  logic        div_op,
    input  logic        divu_op,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);
    import mdu_ctrl_pkg::*;

    localparam logic [4:0] DIV_CNT_INIT = 5'(MDU_DIV_ITERS - 1);
    localparam logic [4:0] MUL_CNT_INIT = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;

    mdu_state_e r_state, w_state_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_a, r_b;
    logic        r_is_div, r_mul_signed, r_q_neg, r_r_neg, r_div0;

    mdu_op_e     w_op;
    logic        w_fire, w_is_mul, w_is_div, w_div_signed, w_commit;
    mdu_state_e  w_op_state;
    logic [31:0] w_abs_a, w_abs_b, w_quot, w_rem, w_res_hi, w_res_lo;
    logic [63:0] w_ext_a, w_ext_b, w_prod;

    assign w_op = mdu_decode({div_op, divu_op, mul_op, mulu_op, hi_we, lo_we});

`ifdef MDU_HILO_FWD_EN
    assign req_ready = (r_state == S_IDLE) || (r_state == S_FINISH);
    assign busy      = (r_state == S_MUL_WAIT) || (r_state == S_DIV_ITER);
`else
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_MUL_WAIT) || (r_state == S_DIV_ITER) ||
                       (r_state == S_FINISH);
`endif

    // A flush drops any request presented in the same cycle
    assign w_fire       = req_valid && req_ready && !cancel;
    assign w_is_div     = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_is_mul     = (w_op == OP_MUL) || (w_op == OP_MULU);
    assign w_div_signed = (w_op == OP_DIV);
    assign w_commit     = (r_state == S_FINISH) && !cancel;
    assign done         = w_commit;

    assign w_op_state = w_is_div ? S_DIV_ITER :
                        w_is_mul ? ((MUL_LAT == 1) ? S_FINISH : S_MUL_WAIT) :
                        S_IDLE;

    assign w_abs_a = (w_div_signed && src1[31]) ? (32'd0 - src1) : src1;
    assign w_abs_b = (w_div_signed && src2[31]) ? (32'd0 - src2) : src2;

    mdu_ctrl_div_iter u_div_iter (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_fire && w_is_div),
        .i_step     (r_state == S_DIV_ITER),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Sign-extending to 64 bits makes one truncated multiply serve both
    // signed and unsigned forms.
    assign w_ext_a = {{32{r_mul_signed & r_a[31]}}, r_a};
    assign w_ext_b = {{32{r_mul_signed & r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Select the result being committed in FINISH, including div sign fix
    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = r_r_neg ? (32'd0 - w_rem)  : w_rem;
                w_res_lo = r_q_neg ? (32'd0 - w_quot) : w_quot;
            end
        end
    end

    // Next-state: new op from IDLE (or FINISH when forwarding), cancel wins
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_fire) w_state_next = w_op_state;
            S_MUL_WAIT: if (r_cnt == 5'd0) w_state_next = S_FINISH;
            S_DIV_ITER: if (r_cnt == 5'd0) w_state_next = S_FINISH;
            S_FINISH:   w_state_next = w_fire ? w_op_state : S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
        if (cancel) w_state_next = S_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Iteration / latency counter
    always_ff @(posedge clk) begin
        if (reset || cancel) begin
            r_cnt <= 5'd0;
        end else if (w_fire && w_is_div) begin
            r_cnt <= DIV_CNT_INIT;
        end else if (w_fire && w_is_mul) begin
            r_cnt <= MUL_CNT_INIT;
        end else if (((r_state == S_MUL_WAIT) || (r_state == S_DIV_ITER)) &&
                     (r_cnt != 5'd0)) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // Capture operands and sign info at accept; inputs are free afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_is_div     <= 1'b0;
            r_mul_signed <= 1'b0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_div0       <= 1'b0;
        end else if (w_fire && (w_is_mul || w_is_div)) begin
            r_a          <= src1;
            r_b          <= src2;
            r_is_div     <= w_is_div;
            r_mul_signed <= (w_op == OP_MUL);
            r_q_neg      <= w_div_signed && (src1[31] ^ src2[31]);
            r_r_neg      <= w_div_signed && src1[31];
            r_div0       <= (src2 == 32'd0);
        end
    end

    // HI/LO: commit in FINISH; an mthi/mtlo accepted the same cycle is younger
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
            if (w_fire && (w_op == OP_MTHI)) r_hi <= src1;
            if (w_fire && (w_op == OP_MTLO)) r_lo <= src1;
        end
    end

    // Read ports, optionally bypassing the value about to be written
    always_comb begin
        hi_rdata = r_hi;
        lo_rdata = r_lo;
`ifdef MDU_HILO_FWD_EN
        if (w_commit) begin
            hi_rdata = w_res_hi;
            lo_rdata = w_res_lo;
        end
        if (w_fire && (w_op == OP_MTHI)) hi_rdata = src1;
        if (w_fire && (w_op == OP_MTLO)) lo_rdata = src1;
`endif
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed table-driven bench for mdu_ctrl plus hand-written
// sequences for cancel, reset, back-to-back mthi/mult and no-op requests.
module tb_mdu_ctrl;

    localparam int TB_MUL_LAT = 2;
    localparam int DIV_LAT    = 33;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready;
    logic        mul_op, mulu_op, div_op, divu_op, hi_we, lo_we;
    logic [31:0] src1, src2;
    logic        cancel, busy, done;
    logic [31:0] hi_rdata, lo_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] cur_hi, cur_lo;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(TB_MUL_LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .mul_op(mul_op), .mulu_op(mulu_op), .div_op(div_op), .divu_op(divu_op),
        .hi_we(hi_we), .lo_we(lo_we), .src1(src1), .src2(src2),
        .cancel(cancel), .busy(busy), .done(done),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
    );

    // op mask bit order: {div, divu, mul, mulu, mthi, mtlo}
    typedef struct {
        logic [5:0]  ops;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_ops(input logic [5:0] ops);
        {div_op, divu_op, mul_op, mulu_op, hi_we, lo_we} = ops;
    endtask

    // Issue one mul/div at the current cycle T and follow it to commit
    task automatic run_op(input logic [5:0] ops, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                          input string nm);
        int k;
        int busy_bad;
        bit got;
        chk({nm, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; set_ops(ops); src1 = a; src2 = b;
        @(negedge clk);
        req_valid = 1'b0; set_ops(6'd0); src1 = $urandom; src2 = $urandom;
        k = 1; got = 1'b0; busy_bad = 0;
        while (k <= 60 && !got) begin
            if (done) got = 1'b1;
            else begin
                if (busy !== 1'b1) busy_bad++;
                @(negedge clk);
                k++;
            end
        end
        chk({nm, " latency"}, k, lat);
        chk({nm, " busy before finish"}, busy_bad, 0);
`ifdef MDU_HILO_FWD_EN
        chk({nm, " finish busy"}, {31'd0, busy}, 32'd0);
        chk({nm, " finish ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, " finish hi"}, hi_rdata, ehi);
        chk({nm, " finish lo"}, lo_rdata, elo);
`else
        chk({nm, " finish busy"}, {31'd0, busy}, 32'd1);
        chk({nm, " finish hi"}, hi_rdata, cur_hi);
        chk({nm, " finish lo"}, lo_rdata, cur_lo);
`endif
        @(negedge clk);
        chk({nm, " hi"}, hi_rdata, ehi);
        chk({nm, " lo"}, lo_rdata, elo);
        chk({nm, " idle busy"}, {31'd0, busy}, 32'd0);
        chk({nm, " idle done"}, {31'd0, done}, 32'd0);
        $display("txn %-14s a=%08h b=%08h lat=%0d hi=%08h lo=%08h", nm, a, b, k, hi_rdata, lo_rdata);
        cur_hi = ehi; cur_lo = elo;
    endtask

    initial begin
        int dcount;
        vecs[0]  = '{6'b001000, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, TB_MUL_LAT, "mult -1*2"};
        vecs[1]  = '{6'b000100, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, TB_MUL_LAT, "multu ffff*2"};
        vecs[2]  = '{6'b001000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, TB_MUL_LAT, "mult -3*5"};
        vecs[3]  = '{6'b000100, 32'h8000_0000, 32'd4,         32'h0000_0002, 32'h0000_0000, TB_MUL_LAT, "multu 2^31*4"};
        vecs[4]  = '{6'b010000, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT,    "divu 100/7"};
        vecs[5]  = '{6'b100000, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT,    "div -7/2"};
        vecs[6]  = '{6'b100000, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT,    "div 7/-2"};
        vecs[7]  = '{6'b100000, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_LAT,    "div 5/0"};
        vecs[8]  = '{6'b010000, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_LAT,    "divu 5/0"};
        vecs[9]  = '{6'b100000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT,    "div ovf"};
        vecs[10] = '{6'b100100, 32'hFFFF_FFFF, 32'd10,        32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT,    "div+mulu prio"};
        // div -1/10 signed: q=0, r=-1

        reset = 1'b1; req_valid = 1'b0; cancel = 1'b0; set_ops(6'd0);
        src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset hi", hi_rdata, 32'd0);
        chk("reset lo", lo_rdata, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset ready", {31'd0, req_ready}, 32'd1);
        cur_hi = 32'd0; cur_lo = 32'd0;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].ops, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].name);

        // divu extra: 0xFFFFFFFF / 10
        run_op(6'b010000, 32'hFFFF_FFFF, 32'd10, DIV_LAT, 32'd5, 32'h1999_9999, "divu max/10");

        // Cancel a divide at T+10
        req_valid = 1'b1; set_ops(6'b010000); src1 = 32'd100; src2 = 32'd7;
        @(negedge clk);
        req_valid = 1'b0; set_ops(6'd0);
        dcount = 0;
        for (int c = 1; c < 10; c++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        cancel = 1'b1;
        #1;
        chk("cancel T+10 done", {31'd0, done}, 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel T+11 busy", {31'd0, busy}, 32'd0);
        chk("cancel T+11 ready", {31'd0, req_ready}, 32'd1);
        chk("cancel T+11 hi", hi_rdata, cur_hi);
        chk("cancel T+11 lo", lo_rdata, cur_lo);
        for (int c = 0; c < 30; c++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("cancel no done", dcount, 0);
        chk("cancel later hi", hi_rdata, cur_hi);
        $display("txn cancel-div   hi=%08h lo=%08h", hi_rdata, lo_rdata);

        // Cancel in the FINISH cycle of a mult
        req_valid = 1'b1; set_ops(6'b001000); src1 = 32'hFFFF_FFFF; src2 = 32'd2;
        @(negedge clk);
        req_valid = 1'b0; set_ops(6'd0);
        dcount = 0;
        while (!done && dcount < 20) begin
            @(negedge clk);
            dcount++;
        end
        chk("finish-cancel reached", {31'd0, done}, 32'd1);
        cancel = 1'b1;
        #1;
        chk("finish-cancel done", {31'd0, done}, 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        chk("finish-cancel hi", hi_rdata, cur_hi);
        chk("finish-cancel lo", lo_rdata, cur_lo);
        chk("finish-cancel ready", {31'd0, req_ready}, 32'd1);
        chk("finish-cancel busy", {31'd0, busy}, 32'd0);
        $display("txn cancel-fin   hi=%08h lo=%08h", hi_rdata, lo_rdata);

        // mthi presented with cancel is dropped
        req_valid = 1'b1; set_ops(6'b000010); src1 = 32'hDEAD_BEEF; cancel = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; set_ops(6'd0); cancel = 1'b0;
        chk("mthi+cancel hi", hi_rdata, cur_hi);
        $display("txn mthi-cancel  hi=%08h", hi_rdata);

        // No-op fire: nothing changes
        req_valid = 1'b1; set_ops(6'd0); src1 = 32'h5555_5555;
        @(negedge clk);
        req_valid = 1'b0;
        chk("noop busy", {31'd0, busy}, 32'd0);
        chk("noop hi", hi_rdata, cur_hi);
        chk("noop lo", lo_rdata, cur_lo);
        $display("txn noop         hi=%08h lo=%08h", hi_rdata, lo_rdata);

        // mthi then back-to-back mult with req_valid held
        req_valid = 1'b1; set_ops(6'b000010); src1 = 32'h0000_1234; src2 = 32'd0;
`ifdef MDU_HILO_FWD_EN
        #1;
        chk("mthi fwd hi", hi_rdata, 32'h0000_1234);
`endif
        @(negedge clk);
        chk("mthi hi", hi_rdata, 32'h0000_1234);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("b2b ready", {31'd0, req_ready}, 32'd1);
        set_ops(6'b001000); src1 = 32'd3; src2 = 32'd5;
        @(negedge clk);
        req_valid = 1'b0; set_ops(6'd0);
        chk("b2b busy", {31'd0, busy}, 32'd1);
        chk("b2b hi held", hi_rdata, 32'h0000_1234);
        @(negedge clk);
        chk("b2b done", {31'd0, done}, 32'd1);
`ifdef MDU_HILO_FWD_EN
        chk("b2b finish lo", lo_rdata, 32'd15);
`else
        chk("b2b finish hi", hi_rdata, 32'h0000_1234);
`endif
        @(negedge clk);
        chk("b2b hi", hi_rdata, 32'd0);
        chk("b2b lo", lo_rdata, 32'd15);
        $display("txn mthi+mult    hi=%08h lo=%08h", hi_rdata, lo_rdata);
        cur_hi = 32'd0; cur_lo = 32'd15;

        // mtlo
        req_valid = 1'b1; set_ops(6'b000001); src1 = 32'h0000_CAFE;
        @(negedge clk);
        req_valid = 1'b0; set_ops(6'd0);
        chk("mtlo lo", lo_rdata, 32'h0000_CAFE);
        chk("mtlo hi", hi_rdata, cur_hi);
        $display("txn mtlo         lo=%08h", lo_rdata);

        // Reset in the middle of a divide
        req_valid = 1'b1; set_ops(6'b100000); src1 = 32'd99; src2 = 32'd4;
        @(negedge clk);
        req_valid = 1'b0; set_ops(6'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset hi", hi_rdata, 32'd0);
        chk("midreset lo", lo_rdata, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset ready", {31'd0, req_ready}, 32'd1);
        dcount = 0;
        for (int c = 0; c < 35; c++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("midreset no done", dcount, 0);
        $display("txn midreset     hi=%08h lo=%08h", hi_rdata, lo_rdata);
        cur_hi = 32'd0; cur_lo = 32'd0;

        // Unit still works after reset
        run_op(6'b000100, 32'd6, 32'd7, TB_MUL_LAT, 32'd0, 32'd42, "multu 6*7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
